// File: rtl/gpio_ctrl_bridge_pkg.sv
// Shared types and GPIO bit-offset constants for the GPIO-to-HLS control bridge.
package gpio_ctrl_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StDone,
    StErr
  } ch_state_e;

  localparam int unsigned CMD_START = 0;
  localparam int unsigned CMD_CLEAR = 1;
  localparam int unsigned ST_BUSY   = 0;
  localparam int unsigned ST_DONE   = 1;
  localparam int unsigned ST_ERR    = 2;
  localparam int unsigned ST_IDLE   = 3;
  localparam int unsigned CH_STRIDE = 4;

endpackage

// File: rtl/gpio_ctrl_channel.sv
// One HLS block handshake: edge-detected start/clear commands, ap_start timeout, sticky status.
module gpio_ctrl_channel
  import gpio_ctrl_bridge_pkg::*;
#(
  parameter int unsigned TimeoutW = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] cmd_i,
  input  logic       finish_i,
  input  logic       idle_i,
  output logic       start_o,
  output logic       complete_o,
  output logic [3:0] status_o
);

  // Counter value one step before saturation; the next increment is the timeout.
  localparam logic [TimeoutW-1:0] CntLast = ~TimeoutW'(1);

  ch_state_e           state_q;
  logic [1:0]          cmd_prev_q;
  logic [1:0]          cmd_edge_q;
  logic [TimeoutW-1:0] cnt_q;
  logic                start_q;
  logic                complete_q;
  logic [3:0]          status_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cmd_prev_q <= '1;
      cmd_edge_q <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      complete_q <= 1'b0;
      status_q   <= '0;
    end else begin
      cmd_prev_q <= cmd_i;
      cmd_edge_q <= cmd_i & ~cmd_prev_q;
      complete_q <= 1'b0;

      status_q[ST_BUSY] <= (state_q == StArm) || (state_q == StRun);
      status_q[ST_DONE] <= (state_q == StDone);
      status_q[ST_ERR]  <= (state_q == StErr);
      status_q[ST_IDLE] <= idle_i;

      case (state_q)
        StIdle: begin
          if (cmd_edge_q[CMD_START]) begin
            state_q <= StArm;
            start_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StArm: begin
          if (!idle_i) begin
            state_q <= StRun;
            start_q <= 1'b0;
          end else if (finish_i) begin
            state_q <= StDone;
            start_q <= 1'b0;
          end else if (cnt_q == CntLast) begin
            state_q <= StErr;
            start_q <= 1'b0;
            cnt_q   <= cnt_q + TimeoutW'(1);
          end else begin
            cnt_q <= cnt_q + TimeoutW'(1);
          end
        end
        StRun: begin
          if (finish_i) state_q <= StDone;
        end
        StDone: begin
          if (cmd_edge_q[CMD_CLEAR]) begin
            state_q    <= StIdle;
            complete_q <= 1'b1;
          end
        end
        StErr: begin
          if (cmd_edge_q[CMD_CLEAR]) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign start_o    = start_q;
  assign complete_o = complete_q;
  assign status_o   = status_q;

endmodule

// File: rtl/gpio_ctrl_bridge.sv
// Maps AXI GPIO bits onto HLS channel FSMs, stretched BRAM reset requests and config bits,
// with all status read back on GPIO_I.
module gpio_ctrl_bridge
  import gpio_ctrl_bridge_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned NUM_RST   = 2,
  parameter int unsigned NUM_CFG   = 2,
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned RST_PULSE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        GPIO_O,
  input  logic [31:0]        GPIO_T,
  output logic [31:0]        GPIO_I,
  output logic [NUM_CH-1:0]  start,
  output logic [NUM_CH-1:0]  complete,
  input  logic [NUM_CH-1:0]  finish,
  input  logic [NUM_CH-1:0]  idle,
  output logic [NUM_RST-1:0] rst_req,
  input  logic [NUM_RST-1:0] rst_busy,
  output logic [NUM_CFG-1:0] cfg
);

  localparam int unsigned RstBase = CH_STRIDE * NUM_CH;
  localparam int unsigned CfgBase = CH_STRIDE * (NUM_CH + NUM_RST);
  localparam int unsigned PcntW   = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  logic [3:0]         ch_status [NUM_CH];
  logic [NUM_RST-1:0] rst_active;
  logic [NUM_CFG-1:0] cfg_q;

  // Tristate controls and reserved command bits carry no meaning here.
  logic unused_gpio;
  assign unused_gpio = ^{GPIO_T, GPIO_O};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gpio_ctrl_channel #(
      .TimeoutW(TIMEOUT_W)
    ) u_ch (
      .clk_i      (clk),
      .rst_i      (rst),
      .cmd_i      ({GPIO_O[CH_STRIDE*i+CMD_CLEAR], GPIO_O[CH_STRIDE*i+CMD_START]}),
      .finish_i   (finish[i]),
      .idle_i     (idle[i]),
      .start_o    (start[i]),
      .complete_o (complete[i]),
      .status_o   (ch_status[i])
    );
  end

  for (genvar j = 0; j < NUM_RST; j++) begin : g_rst
    logic             cmd;
    logic             prev_q;
    logic             edge_q;
    logic             active_q;
    logic             req_q;
    logic [PcntW-1:0] pcnt_q;

    assign cmd = GPIO_O[RstBase+CH_STRIDE*j+CMD_START];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev_q   <= 1'b1;
        edge_q   <= 1'b0;
        active_q <= 1'b0;
        req_q    <= 1'b0;
        pcnt_q   <= '0;
      end else begin
        prev_q <= cmd;
        edge_q <= cmd & ~prev_q;
        if (!active_q) begin
          if (edge_q) begin
            active_q <= 1'b1;
            req_q    <= 1'b1;
            pcnt_q   <= '0;
          end
        end else if (req_q) begin
          if (pcnt_q == PcntW'(RST_PULSE - 1)) req_q <= 1'b0;
          else pcnt_q <= pcnt_q + PcntW'(1);
        end else if (!rst_busy[j]) begin
          active_q <= 1'b0;
        end
      end
    end

    assign rst_req[j]    = req_q;
    assign rst_active[j] = active_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_q <= '0;
    else     cfg_q <= GPIO_O[CfgBase +: NUM_CFG];
  end

  assign cfg = cfg_q;

  always_comb begin
    GPIO_I = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      GPIO_I[CH_STRIDE*i +: 4] = ch_status[i];
    end
    for (int j = 0; j < NUM_RST; j++) begin
      GPIO_I[RstBase+CH_STRIDE*j +: 4] = {2'b11, rst_busy[j], rst_active[j]};
    end
    GPIO_I[CfgBase +: NUM_CFG] = cfg_q;
  end

endmodule

// File: tb/tb_gpio_ctrl_bridge.sv
// Directed bench for gpio_ctrl_bridge with a cycle model checked every clock.
module tb_gpio_ctrl_bridge;

  localparam int NCH  = 4;
  localparam int NRST = 2;
  localparam int NCFG = 2;
  localparam int TW   = 4;
  localparam int RP   = 4;
  localparam int TMAX = (1 << TW) - 1;

  localparam int S_IDLE = 0;
  localparam int S_ARM  = 1;
  localparam int S_RUN  = 2;
  localparam int S_DONE = 3;
  localparam int S_ERR  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     gpio_o;
  logic [31:0]     gpio_t;
  logic [31:0]     gpio_i;
  logic [NCH-1:0]  start;
  logic [NCH-1:0]  complete;
  logic [NCH-1:0]  finish;
  logic [NCH-1:0]  idle;
  logic [NRST-1:0] rst_req;
  logic [NRST-1:0] rst_busy;
  logic [NCFG-1:0] cfg;

  int checks;
  int failures;

  gpio_ctrl_bridge #(
    .NUM_CH   (NCH),
    .NUM_RST  (NRST),
    .NUM_CFG  (NCFG),
    .TIMEOUT_W(TW),
    .RST_PULSE(RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .GPIO_O   (gpio_o),
    .GPIO_T   (gpio_t),
    .GPIO_I   (gpio_i),
    .start    (start),
    .complete (complete),
    .finish   (finish),
    .idle     (idle),
    .rst_req  (rst_req),
    .rst_busy (rst_busy),
    .cfg      (cfg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: channel phases, reset pulse length, config echo.
  int              m_st   [NCH];
  int              m_cnt  [NCH];
  logic [3:0]      m_status [NCH];
  logic [NCH-1:0]  m_start;
  logic [NCH-1:0]  m_complete;
  logic [31:0]     m_prev;
  logic [31:0]     m_edge;
  int              m_rlen [NRST];
  logic [NRST-1:0] m_ract;
  logic [NRST-1:0] m_req;
  logic [NCFG-1:0] m_cfg;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_st[i] = S_IDLE;
        m_cnt[i] = 0;
        m_status[i] = 4'b0000;
      end
      for (int j = 0; j < NRST; j++) m_rlen[j] = 0;
      m_start = '0;
      m_complete = '0;
      m_ract = '0;
      m_req = '0;
      m_cfg = '0;
      m_prev = '1;
      m_edge = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        int s;
        s = m_st[i];
        m_status[i] = {idle[i], s == S_ERR, s == S_DONE, (s == S_ARM) || (s == S_RUN)};
        m_complete[i] = 1'b0;
        case (s)
          S_IDLE: if (m_edge[4*i]) begin s = S_ARM; m_cnt[i] = 0; end
          S_ARM: begin
            if (!idle[i]) s = S_RUN;
            else if (finish[i]) s = S_DONE;
            else begin
              m_cnt[i]++;
              if (m_cnt[i] == TMAX) s = S_ERR;
            end
          end
          S_RUN:  if (finish[i]) s = S_DONE;
          S_DONE: if (m_edge[4*i+1]) begin s = S_IDLE; m_complete[i] = 1'b1; end
          S_ERR:  if (m_edge[4*i+1]) s = S_IDLE;
          default: s = S_IDLE;
        endcase
        m_st[i] = s;
        m_start[i] = (s == S_ARM);
      end
      for (int j = 0; j < NRST; j++) begin
        if (!m_ract[j]) begin
          if (m_edge[4*NCH+4*j]) begin
            m_ract[j] = 1'b1;
            m_req[j] = 1'b1;
            m_rlen[j] = 1;
          end
        end else if (m_req[j]) begin
          if (m_rlen[j] == RP) m_req[j] = 1'b0;
          else m_rlen[j]++;
        end else if (!rst_busy[j]) begin
          m_ract[j] = 1'b0;
        end
      end
      m_cfg = gpio_o[4*(NCH+NRST) +: NCFG];
      m_edge = gpio_o & ~m_prev;
      m_prev = gpio_o;
    end
  end

  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    e = '1;
    for (int i = 0; i < NCH; i++) e[4*i +: 4] = m_status[i];
    for (int j = 0; j < NRST; j++) e[4*NCH+4*j +: 4] = {2'b11, rst_busy[j], m_ract[j]};
    e[4*(NCH+NRST) +: NCFG] = m_cfg;
    check("cmp_start", start, m_start);
    check("cmp_complete", complete, m_complete);
    check("cmp_rst_req", rst_req, m_req);
    check("cmp_cfg", cfg, m_cfg);
    check("cmp_gpio_i", gpio_i, e);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hi;
    int cp;
    int sh;
    int rq;
    int rises;
    logic prev_req;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    gpio_o = '0;
    gpio_t = 32'hA5A5_5A5A;
    finish = '0;
    idle = '1;
    rst_busy = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_start", start, 0);
    check("rst_complete", complete, 0);
    check("rst_rst_req", rst_req, 0);
    check("rst_cfg", cfg, 0);
    check("rst_ch0_status", gpio_i[3:0], 4'b1000);
    check("rst_unused_hi", gpio_i[31:26], 6'h3f);
    check("rst_rstch_fixed", {gpio_i[23:22], gpio_i[19:18]}, 4'hf);

    // Normal run on channel 0
    gpio_o[0] = 1'b1;
    lat = 0;
    while (lat < 10 && start[0] !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    check("start_latency", lat, 2);
    hi = 1;
    @(negedge clk); hi += int'(start[0]);
    @(negedge clk); hi += int'(start[0]);
    idle[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      hi += int'(start[0]);
      if (k == 1) gpio_o[0] = 1'b0;
      if (k == 2) gpio_o[0] = 1'b1;
    end
    check("start_high_cycles", hi, 3);
    repeat (4) @(negedge clk);
    finish[0] = 1'b1;
    @(negedge clk);
    finish[0] = 1'b0;
    idle[0] = 1'b1;
    @(negedge clk);
    check("done_status", gpio_i[3:0], 4'b1010);
    gpio_o[1] = 1'b1;
    cp = 0;
    sh = 0;
    repeat (8) begin
      @(negedge clk);
      cp += int'(complete[0]);
      sh += int'(start[0]);
    end
    check("complete_pulses", cp, 1);
    check("no_second_start", sh, 0);
    check("idle_after_clear", gpio_i[3:0], 4'b1000);
    gpio_o[1:0] = 2'b00;

    // Start timeout on channel 1
    @(negedge clk);
    gpio_o[4] = 1'b1;
    lat = 0;
    while (lat < 10 && start[1] !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    check("ch1_start_seen", start[1], 1);
    hi = 0;
    while (hi < 40 && start[1] === 1'b1) begin
      hi++;
      @(negedge clk);
    end
    check("timeout_cycles", hi, 15);
    @(negedge clk);
    check("err_flag", gpio_i[6:4], 3'b100);
    gpio_o[5] = 1'b1;
    cp = 0;
    repeat (8) begin
      @(negedge clk);
      cp += int'(complete[1]);
    end
    check("err_clear_no_complete", cp, 0);
    check("err_cleared", gpio_i[6], 0);
    gpio_o[5:4] = 2'b00;

    // Start bit held high through reset must not fire
    @(negedge clk);
    gpio_o[8] = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sh = 0;
    repeat (8) begin
      @(negedge clk);
      sh += int'(start[2]);
    end
    check("held_thru_reset", sh, 0);

    // Asynchronous reset while channel 3 is arming
    gpio_o[12] = 1'b1;
    lat = 0;
    while (lat < 10 && start[3] !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    check("ch3_start_seen", start[3], 1);
    #2 rst = 1'b1;
    #1;
    check("async_start_drop", start[3], 0);
    check("async_status_clear", gpio_i[15:12], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gpio_o = '0;
    repeat (2) @(negedge clk);

    // Reset channel 0: stretched pulse and busy wait
    gpio_o[16] = 1'b1;
    lat = 0;
    while (lat < 10 && rst_req[0] !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    check("rst_req_latency", lat, 2);
    rq = 0;
    rises = 0;
    prev_req = 1'b0;
    for (int k = 0; k < 14; k++) begin
      rq += int'(rst_req[0]);
      if (rst_req[0] && !prev_req) rises++;
      prev_req = rst_req[0];
      if (k == 0) rst_busy[0] = 1'b1;
      if (k == 1) gpio_o[16] = 1'b0;
      if (k == 2) gpio_o[16] = 1'b1;
      if (k == 5) check("active_while_busy", gpio_i[16], 1);
      if (k == 6) rst_busy[0] = 1'b0;
      if (k == 7) check("inactive_after_busy", gpio_i[16], 0);
      @(negedge clk);
    end
    check("rst_req_cycles", rq, 4);
    check("rst_req_single", rises, 1);
    gpio_o[16] = 1'b0;

    // Config bits
    @(negedge clk);
    gpio_o[25:24] = 2'b11;
    @(negedge clk);
    check("cfg_11", cfg, 2'b11);
    check("cfg_echo_11", gpio_i[25:24], 2'b11);
    gpio_o[25:24] = 2'b10;
    @(negedge clk);
    check("cfg_10", cfg, 2'b10);
    check("cfg_echo_10", gpio_i[25:24], 2'b10);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
